// File: rtl/coefficient_calculator_controller.sv
// coefficient_calculator_controller
//   Moore FSM sequencing the linear-regression coefficient datapath over
//   N_SAMPLES samples. Pass 1 accumulates sum(X) and sum(Y) and then forms
//   the two means. Pass 2 accumulates SSxx and SSxy and then loads B1 and B0.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           run request, only acted upon in IDLE
//   busy            high from INIT through CALC_B0
//   done            one-cycle pulse once B0/B1 are valid
//   addr            sample memory address (memory read is combinational)
//   ldX, ldY        load the X/Y sample registers
//   clrSum*/ldSum*  sum register clear/accumulate
//   divideXbarY     mean divider source: 0 = sumX, 1 = sumY
//   ldMeanX/Y       mean register loads
//   subForYiOrB0    0 = (Yi - meanY), 1 = (meanY - B1*meanX)
//   multForXiOrB0   0 = (Xi - meanX)^2, 1 = B1*meanX
//   clrSS*/ldSS*    SS register clear/accumulate
//   ldB0, ldB1      coefficient register loads
module coefficient_calculator_controller #(
  parameter int unsigned N_SAMPLES = 150,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              ldX,
  output logic              ldY,
  output logic              clrSumX,
  output logic              clrSumY,
  output logic              ldSumX,
  output logic              ldSumY,
  output logic              divideXbarY,
  output logic              ldMeanX,
  output logic              ldMeanY,
  output logic              subForYiOrB0,
  output logic              multForXiOrB0,
  output logic              clrSSxx,
  output logic              clrSSxy,
  output logic              ldSSxx,
  output logic              ldSSxy,
  output logic              ldB0,
  output logic              ldB1
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_P1_LOAD,
    S_P1_ACC,
    S_MEAN_X,
    S_MEAN_Y,
    S_P2_LOAD,
    S_P2_ACC,
    S_CALC_B1,
    S_CALC_B0,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state and address. The address only moves in INIT and the two
  // accumulate states, wrapping to 0 after the last sample of each pass.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_INIT;
      S_INIT: begin
        addr_d  = '0;
        state_d = S_P1_LOAD;
      end
      S_P1_LOAD: state_d = S_P1_ACC;
      S_P1_ACC: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_MEAN_X;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_P1_LOAD;
        end
      end
      S_MEAN_X:  state_d = S_MEAN_Y;
      S_MEAN_Y:  state_d = S_P2_LOAD;
      S_P2_LOAD: state_d = S_P2_ACC;
      S_P2_ACC: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_CALC_B1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_P2_LOAD;
        end
      end
      S_CALC_B1: state_d = S_CALC_B0;
      S_CALC_B0: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore output decode: every control is a function of state alone.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    ldX           = 1'b0;
    ldY           = 1'b0;
    clrSumX       = 1'b0;
    clrSumY       = 1'b0;
    ldSumX        = 1'b0;
    ldSumY        = 1'b0;
    divideXbarY   = 1'b0;
    ldMeanX       = 1'b0;
    ldMeanY       = 1'b0;
    subForYiOrB0  = 1'b0;
    multForXiOrB0 = 1'b0;
    clrSSxx       = 1'b0;
    clrSSxy       = 1'b0;
    ldSSxx        = 1'b0;
    ldSSxy        = 1'b0;
    ldB0          = 1'b0;
    ldB1          = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_INIT: begin
        busy    = 1'b1;
        clrSumX = 1'b1;
        clrSumY = 1'b1;
        clrSSxx = 1'b1;
        clrSSxy = 1'b1;
      end
      S_P1_LOAD, S_P2_LOAD: begin
        busy = 1'b1;
        ldX  = 1'b1;
        ldY  = 1'b1;
      end
      S_P1_ACC: begin
        busy   = 1'b1;
        ldSumX = 1'b1;
        ldSumY = 1'b1;
      end
      S_MEAN_X: begin
        busy    = 1'b1;
        ldMeanX = 1'b1;
      end
      S_MEAN_Y: begin
        busy        = 1'b1;
        divideXbarY = 1'b1;
        ldMeanY     = 1'b1;
      end
      S_P2_ACC: begin
        busy   = 1'b1;
        ldSSxx = 1'b1;
        ldSSxy = 1'b1;
      end
      S_CALC_B1: begin
        busy = 1'b1;
        ldB1 = 1'b1;
      end
      S_CALC_B0: begin
        busy          = 1'b1;
        subForYiOrB0  = 1'b1;
        multForXiOrB0 = 1'b1;
        ldB0          = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign addr = addr_q;

endmodule

// File: tb/tb_coefficient_calculator_controller.sv
module tb_coefficient_calculator_controller;

  localparam int N = 150;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] addr;
    logic       ldX, ldY, clrSumX, clrSumY, ldSumX, ldSumY;
    logic       divideXbarY, ldMeanX, ldMeanY, subFor, multFor;
    logic       clrSSxx, clrSSxy, ldSSxx, ldSSxy, ldB0, ldB1;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [7:0] addr;
  logic       ldX, ldY, clrSumX, clrSumY, ldSumX, ldSumY;
  logic       divideXbarY, ldMeanX, ldMeanY, subForYiOrB0, multForXiOrB0;
  logic       clrSSxx, clrSSxy, ldSSxx, ldSSxy, ldB0, ldB1;

  coefficient_calculator_controller #(.N_SAMPLES(N), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .addr(addr),
    .ldX(ldX), .ldY(ldY), .clrSumX(clrSumX), .clrSumY(clrSumY),
    .ldSumX(ldSumX), .ldSumY(ldSumY), .divideXbarY(divideXbarY),
    .ldMeanX(ldMeanX), .ldMeanY(ldMeanY), .subForYiOrB0(subForYiOrB0),
    .multForXiOrB0(multForXiOrB0), .clrSSxx(clrSSxx), .clrSSxy(clrSSxy),
    .ldSSxx(ldSSxx), .ldSSxy(ldSSxy), .ldB0(ldB0), .ldB1(ldB1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- schedule model: expected control word per cycle -------
  ctl_t   q[$];
  ctl_t   cur;
  bit     m_idle  = 1'b1;
  bit     armed   = 1'b0;
  longint cyc     = 0;
  longint t_start = 0;

  function automatic ctl_t busy_word(input int a);
    ctl_t v = '0;
    v.busy = 1'b1;
    v.addr = 8'(a);
    return v;
  endfunction

  // A run is INIT, N load/acc pairs, two mean steps, N load/acc pairs,
  // B1, B0, then a single DONE cycle.
  function automatic void build_run();
    ctl_t v;
    v = busy_word(0);
    v.clrSumX = 1; v.clrSumY = 1; v.clrSSxx = 1; v.clrSSxy = 1;
    q.push_back(v);
    for (int p = 1; p <= 2; p++) begin
      for (int i = 0; i < N; i++) begin
        v = busy_word(i); v.ldX = 1; v.ldY = 1; q.push_back(v);
        v = busy_word(i);
        if (p == 1) begin v.ldSumX = 1; v.ldSumY = 1; end
        else        begin v.ldSSxx = 1; v.ldSSxy = 1; end
        q.push_back(v);
      end
      if (p == 1) begin
        v = busy_word(0); v.ldMeanX = 1; q.push_back(v);
        v = busy_word(0); v.divideXbarY = 1; v.ldMeanY = 1; q.push_back(v);
      end
    end
    v = busy_word(0); v.ldB1 = 1; q.push_back(v);
    v = busy_word(0); v.subFor = 1; v.multFor = 1; v.ldB0 = 1; q.push_back(v);
    v = '0; v.done = 1; q.push_back(v);
  endfunction

  // ---------------- behavioural datapath driven by the controller ---------
  longint xm[N], ym[N];
  longint xr, yr, sumX, sumY, meanX, meanY, ssxx, ssxy, b1, b0;

  int cnt_sum = 0, cnt_ss = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (clrSumX) sumX = 0;
      if (clrSumY) sumY = 0;
      if (clrSSxx) ssxx = 0;
      if (clrSSxy) ssxy = 0;
      if (ldSumX) sumX += xr;
      if (ldSumY) sumY += yr;
      if (ldSSxx) ssxx += (xr - meanX) * (xr - meanX);
      if (ldSSxy) ssxy += (xr - meanX) * (yr - meanY);
      if (ldMeanX) meanX = (divideXbarY ? sumY : sumX) / N;
      if (ldMeanY) meanY = (divideXbarY ? sumY : sumX) / N;
      if (ldB1) b1 = (ssxx == 0) ? 0 : (ssxy <<< 10) / ssxx;
      if (ldB0) b0 = meanY - ((b1 * meanX) >>> 10);
      if (ldX) xr = xm[addr];
      if (ldY) yr = ym[addr];
    end
    if (rst) begin
      q.delete();
      cur    = '0;
      m_idle = 1'b1;
    end else if (m_idle && start) begin
      build_run();
      cur     = q.pop_front();
      m_idle  = 1'b0;
      t_start = cyc;
      cnt_sum = 0;
      cnt_ss  = 0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur    = '0;
      m_idle = 1'b1;
    end
    armed = 1'b1;
  end

  // ---------------- per-cycle compare plus run-level timing checks --------
  bit     b2b       = 1'b0;
  longint prev_done = -1;
  int     low_cnt   = 0;
  int     hi_cnt    = 0;
  int     done_cnt  = 0;

  always @(negedge clk) begin
    ctl_t act;
    if (armed) begin
      act = {busy, done, addr, ldX, ldY, clrSumX, clrSumY, ldSumX, ldSumY,
             divideXbarY, ldMeanX, ldMeanY, subForYiOrB0, multForXiOrB0,
             clrSSxx, clrSSxy, ldSSxx, ldSSxy, ldB0, ldB1};
      total++;
      if (act !== cur) begin
        bad++;
        $display("FAIL ctrl cyc=%0d got=%h want=%h", cyc, act, cur);
      end
      if (ldSumX) cnt_sum++;
      if (ldSSxx) cnt_ss++;
      if (rst) hi_cnt = 0;
      else if (busy) hi_cnt++;
      else if (hi_cnt > 0) begin
        chk("busy_len", hi_cnt, 605);
        hi_cnt = 0;
      end
      if (done) begin
        done_cnt++;
        chk("latency", cyc - t_start, 605);
        chk("n_sum", cnt_sum, 150);
        chk("n_ss", cnt_ss, 150);
        if (b2b && prev_done >= 0) chk("period", cyc - prev_done, 607);
        prev_done = cyc;
      end
      if (b2b && prev_done >= 0) begin
        if (!busy) low_cnt++;
        else if (low_cnt > 0) begin
          chk("busy_low", low_cnt, 2);
          low_cnt = 0;
        end
      end
    end
  end

  task automatic wait_for(input int which, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((which == 0 && done) || (which == 1 && ldB1) ||
          (which == 2 && ldSSxx) || (which == 3 && ldSumX)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_ok", longint'(ok), 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  int saved;

  initial begin
    for (int i = 0; i < N; i++) begin
      xm[i] = 2 * i;
      ym[i] = 4 * i + 1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);

    // Linear data: full trace plus datapath results.
    pulse_start();
    wait_for(0, 700);
    @(negedge clk);
    chk("meanX", meanX, 149);
    chk("meanY", meanY, 299);
    chk("ssxx", ssxx, 1124950);
    chk("ssxy", ssxy, 2249900);
    chk("B1", b1, 2048);
    chk("B0", b0, 1);

    // start pulses mid-run must not disturb the sequence.
    pulse_start();
    wait_for(3, 20);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_for(1, 700);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_for(0, 20);
    repeat (3) @(negedge clk);
    chk("no_restart", busy, 0);

    // Constant data: SSxx is zero but the run still completes.
    for (int i = 0; i < N; i++) begin
      xm[i] = 5;
      ym[i] = 7;
    end
    pulse_start();
    wait_for(0, 700);
    @(negedge clk);
    chk("const_ssxx", ssxx, 0);

    // start held high: back-to-back runs.
    @(posedge clk); #1;
    b2b = 1'b1; prev_done = -1; low_cnt = 0;
    start = 1'b1;
    repeat (1500) @(posedge clk);
    #1 start = 1'b0;
    wait_for(0, 700);
    b2b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_runs", done_cnt, 6);

    // Reset in the middle of pass 2 aborts the run.
    pulse_start();
    wait_for(2, 700);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_addr", addr, 0);
    chk("abort_ldss", ldSSxx, 0);
    saved = done_cnt;
    repeat (700) @(negedge clk);
    chk("abort_nodone", done_cnt, saved);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
